// File: rtl/uart_trans.sv
// UART transmit side: on start, strobes recSig for one bit period, idles the lead-in,
// then serialises the captured word LSB-first on bsOut with a one-clk done pulse.
module uart_trans #(
  parameter int unsigned PACKET_SIZE = 4,
  parameter int unsigned CYCLE_DIV   = 100,
  parameter int unsigned LEAD_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   start,
  input  logic [PACKET_SIZE-1:0] dataIn,
  output logic                   bsOut,
  output logic                   recSig,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CntW  = ($clog2(CYCLE_DIV) > 0) ? $clog2(CYCLE_DIV) : 1;
  localparam int unsigned IdxW  = ($clog2(PACKET_SIZE + 1) > 0) ? $clog2(PACKET_SIZE + 1) : 1;
  localparam int unsigned LeadW = ($clog2(LEAD_CYCLES + 1) > 0) ? $clog2(LEAD_CYCLES + 1) : 1;
  // Index of the final lead period; unused when LEAD_CYCLES == 1.
  localparam int unsigned LeadLast = (LEAD_CYCLES >= 2) ? LEAD_CYCLES - 2 : 0;

  typedef enum logic [1:0] {StIdle, StSignal, StLead, StData} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        bit_idx_q, bit_idx_d;
  logic [LeadW-1:0]       lead_q, lead_d;
  logic [PACKET_SIZE-1:0] shift_q, shift_d;
  logic                   bs_q, bs_d;
  logic                   rec_q, rec_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tick;

  assign tick = (cnt_q == CntW'(CYCLE_DIV - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    lead_d    = lead_q;
    shift_d   = shift_q;
    done_d    = 1'b0;

    if (state_q == StIdle) begin
      cnt_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d   = dataIn;
          bit_idx_d = '0;
          lead_d    = '0;
          state_d   = StSignal;
        end
      end
      StSignal: begin
        if (tick) begin
          lead_d  = '0;
          state_d = (LEAD_CYCLES == 1) ? StData : StLead;
        end
      end
      StLead: begin
        if (tick) begin
          if (lead_q == LeadW'(LeadLast)) begin
            state_d = StData;
          end else begin
            lead_d = lead_q + LeadW'(1);
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + IdxW'(1);
          if (bit_idx_q == IdxW'(PACKET_SIZE - 1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they appear registered.
    bs_d   = (state_d == StData) ? shift_d[0] : 1'b1;
    rec_d  = (state_d == StSignal);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      lead_q    <= '0;
      shift_q   <= '0;
      bs_q      <= 1'b1;
      rec_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      lead_q    <= lead_d;
      shift_q   <= shift_d;
      bs_q      <= bs_d;
      rec_q     <= rec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bsOut  = bs_q;
  assign recSig = rec_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
